// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-block-memory arbiter slice.
package cache_pkg;

    localparam int SRAM_ADDR_BIT = 9;
    localparam int SRAM_DATA_BIT = 1024;
    localparam int RD_LATENCY    = 2;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/cache_sram_arbiter_if.sv
// Bundle of the two cache request ports and the shared block-memory port A.
interface cache_sram_arbiter_if #(
    parameter int SRAM_ADDR_BIT = cache_pkg::SRAM_ADDR_BIT,
    parameter int SRAM_DATA_BIT = cache_pkg::SRAM_DATA_BIT
);

    logic                     M0_req_i;
    logic                     M1_req_i;
    logic                     M0_wea_i;
    logic                     M1_wea_i;
    logic [SRAM_ADDR_BIT-1:0] M0_addr_i;
    logic [SRAM_ADDR_BIT-1:0] M1_addr_i;
    logic [SRAM_DATA_BIT-1:0] M0_data_i;
    logic [SRAM_DATA_BIT-1:0] M1_data_i;
    logic                     M0_gnt_o;
    logic                     M1_gnt_o;
    logic                     M0_rvalid_o;
    logic                     M1_rvalid_o;
    logic [SRAM_DATA_BIT-1:0] M_rdata_o;
    logic                     SRAM_ena_o;
    logic                     SRAM_wea_o;
    logic [SRAM_ADDR_BIT-1:0] SRAM_addr_o;
    logic [SRAM_DATA_BIT-1:0] SRAM_data_o;
    logic [SRAM_DATA_BIT-1:0] SRAM_data_i;

    // The arbiter side.
    modport slave (
        input  M0_req_i, M1_req_i, M0_wea_i, M1_wea_i,
        input  M0_addr_i, M1_addr_i, M0_data_i, M1_data_i,
        input  SRAM_data_i,
        output M0_gnt_o, M1_gnt_o, M0_rvalid_o, M1_rvalid_o, M_rdata_o,
        output SRAM_ena_o, SRAM_wea_o, SRAM_addr_o, SRAM_data_o
    );

    // The caches plus the memory macro, seen as one environment.
    modport master (
        output M0_req_i, M1_req_i, M0_wea_i, M1_wea_i,
        output M0_addr_i, M1_addr_i, M0_data_i, M1_data_i,
        output SRAM_data_i,
        input  M0_gnt_o, M1_gnt_o, M0_rvalid_o, M1_rvalid_o, M_rdata_o,
        input  SRAM_ena_o, SRAM_wea_o, SRAM_addr_o, SRAM_data_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant combinator; the pointer flips away from each accepted winner.
module rr_arb2
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       gnt_accept,
    output logic [1:0] gnt,
    output req_id_e    winner
);

    logic prio_q;

    // A lone requester always wins; prio_q only breaks ties.
    always_comb begin
        winner = REQ_M0;
        gnt    = 2'b00;
        if (req[1] && (!req[0] || prio_q)) begin
            winner = REQ_M1;
        end
        if (!rst) begin
            gnt[0] = req[0] && (winner == REQ_M0);
            gnt[1] = req[1] && (winner == REQ_M1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (gnt_accept) begin
            prio_q <= (winner == REQ_M0);
        end
    end

    onehot_gnt_a: assert property (@(posedge clk) disable iff (rst) !(gnt[0] && gnt[1]));

endmodule

// File: rtl/cache_sram_arbiter.sv
// Shares block-memory port A between two caches: registered command, tagged in-order read return.
module cache_sram_arbiter #(
    parameter int SRAM_ADDR_BIT = cache_pkg::SRAM_ADDR_BIT,
    parameter int SRAM_DATA_BIT = cache_pkg::SRAM_DATA_BIT,
    parameter int RD_LATENCY    = cache_pkg::RD_LATENCY
) (
    input logic                 clk_sys_i,
    input logic                 rst_sys_i,
    cache_sram_arbiter_if.slave bus
);

    import cache_pkg::*;

    logic [1:0]               gnt;
    logic                     any_gnt;
    req_id_e                  winner;
    logic                     win_wea;
    logic [SRAM_ADDR_BIT-1:0] win_addr;
    logic [SRAM_DATA_BIT-1:0] win_data;

    rr_arb2 u_arb (
        .clk        (clk_sys_i),
        .rst        (rst_sys_i),
        .req        ({bus.M1_req_i, bus.M0_req_i}),
        .gnt_accept (any_gnt),
        .gnt        (gnt),
        .winner     (winner)
    );

    assign any_gnt      = |gnt;
    assign bus.M0_gnt_o = gnt[0];
    assign bus.M1_gnt_o = gnt[1];

    always_comb begin
        win_wea  = bus.M0_wea_i;
        win_addr = bus.M0_addr_i;
        win_data = bus.M0_data_i;
        if (winner == REQ_M1) begin
            win_wea  = bus.M1_wea_i;
            win_addr = bus.M1_addr_i;
            win_data = bus.M1_data_i;
        end
    end

    // Command register: the winner's command is on port A the cycle after its grant.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            bus.SRAM_ena_o  <= 1'b0;
            bus.SRAM_wea_o  <= 1'b0;
            bus.SRAM_addr_o <= '0;
            bus.SRAM_data_o <= '0;
        end else begin
            bus.SRAM_ena_o <= any_gnt;
            bus.SRAM_wea_o <= any_gnt && win_wea;
            if (any_gnt) begin
                bus.SRAM_addr_o <= win_addr;
                bus.SRAM_data_o <= win_data;
            end
        end
    end

    // Stage 0 rides alongside the command register, so the last stage lines up
    // with douta RD_LATENCY cycles after the command is on the port.
    rd_tag_t tag_q [0:RD_LATENCY];

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= any_gnt && !win_wea;
            tag_q[0].owner <= (winner == REQ_M1);
            for (int i = 1; i <= RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign bus.M0_rvalid_o = tag_q[RD_LATENCY].valid && !tag_q[RD_LATENCY].owner;
    assign bus.M1_rvalid_o = tag_q[RD_LATENCY].valid &&  tag_q[RD_LATENCY].owner;
    assign bus.M_rdata_o   = bus.SRAM_data_i;

endmodule
